bomb_scheduler: RTL and testbench

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomberman_pkg.sv | 16 +
 rtl/bomb_slot.sv | 76 +++++++
 rtl/bomb_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bomb_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomb scheduler: slot state enum,
// tile/slot sizing and the default fuse and blast lengths in frame ticks.
package bomberman_pkg;

  localparam int TILE_W              = 7;
  localparam int MAX_BOMBS           = 6;
  localparam int DEFAULT_FUSE_TICKS  = 180;
  localparam int DEFAULT_BLAST_TICKS = 30;

  typedef enum logic [1:0] {
    SLOT_IDLE      = 2'd0,
    SLOT_ARMED     = 2'd1,
    SLOT_EXPLODING = 2'd2
  } slot_state_t;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> ARMED (fuse countdown) -> EXPLODING (blast countdown) -> IDLE.
// The current state is exposed on the state port so checkers can bind to it.
module bomb_slot
  import bomberman_pkg::*;
#(
  parameter logic [7:0] FUSE_TICKS  = 8'(DEFAULT_FUSE_TICKS),
  parameter logic [7:0] BLAST_TICKS = 8'(DEFAULT_BLAST_TICKS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              tick,
  input  logic              alloc,
  input  logic [TILE_W-1:0] alloc_tile,
  input  logic              alloc_owner,
  input  logic              chain_hit,
  output slot_state_t       state,
  output logic [TILE_W-1:0] tile,
  output logic              owner,
  output logic              fire
);

  slot_state_t state_next;
  logic [7:0]  timer;
  logic        last_tick;

  always_ff @(posedge clock) begin
    if (reset || clear) state <= SLOT_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    last_tick  = tick && (timer == 8'd1);
    state_next = state;
    case (state)
      SLOT_IDLE:      if (alloc) state_next = SLOT_ARMED;
      SLOT_ARMED:     if (last_tick || chain_hit) state_next = SLOT_EXPLODING;
      SLOT_EXPLODING: if (last_tick) state_next = SLOT_IDLE;
      default:        state_next = SLOT_IDLE;
    endcase
  end

  // fire marks the cycle whose closing edge moves ARMED to EXPLODING.
  always_comb begin
    fire = (state == SLOT_ARMED) && (last_tick || chain_hit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
      tile  <= '0;
      owner <= 1'b0;
    end else if (clear) begin
      timer <= '0;
    end else begin
      case (state)
        SLOT_IDLE: begin
          if (alloc) begin
            timer <= FUSE_TICKS;
            tile  <= alloc_tile;
            owner <= alloc_owner;
          end
        end
        SLOT_ARMED: begin
          if (fire)      timer <= BLAST_TICKS;
          else if (tick) timer <= timer - 8'd1;
        end
        SLOT_EXPLODING: begin
          if (tick) timer <= timer - 8'd1;
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: rtl/bomb_scheduler.sv
// Six-slot bomb scheduler: placement arbitration between two players, per-player
// live limits, detonation serializer and a combinational slot read port.
// Defining BOMB_CHAIN_EN adds chain_valid/chain_tile chain-detonation inputs.
module bomb_scheduler
  import bomberman_pkg::*;
#(
  parameter int FUSE_TICKS   = DEFAULT_FUSE_TICKS,
  parameter int BLAST_TICKS  = DEFAULT_BLAST_TICKS,
  parameter int PLAYER_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              clear,
`ifdef BOMB_CHAIN_EN
  input  logic              chain_valid,
  input  logic [TILE_W-1:0] chain_tile,
`endif
  input  logic              p1_place,
  input  logic              p2_place,
  input  logic [TILE_W-1:0] p1_tile,
  input  logic [TILE_W-1:0] p2_tile,
  output logic              p1_grant,
  output logic              p2_grant,
  output logic              p1_deny,
  output logic              p2_deny,
  input  logic [2:0]        bomb_id,
  output logic              bomb_active,
  output logic              bomb_exploding,
  output logic [TILE_W-1:0] bomb_tile,
  output logic              explode_start,
  output logic [TILE_W-1:0] explode_tile
);

  slot_state_t           slot_state [MAX_BOMBS];
  logic [TILE_W-1:0]     slot_tile  [MAX_BOMBS];
  logic                  slot_owner [MAX_BOMBS];
  logic [MAX_BOMBS-1:0]  fire;
  logic [MAX_BOMBS-1:0]  chain_hit;
  logic [MAX_BOMBS-1:0]  alloc_vec;
  logic [MAX_BOMBS-1:0]  free_onehot;
  logic [MAX_BOMBS-1:0]  pending;
  logic [MAX_BOMBS-1:0]  pending_next;

  logic                  prio_p2;
  logic                  req1, req2, pick_p2, any_req;
  logic [TILE_W-1:0]     want_tile;
  logic                  tile_taken, has_idle, accept, reject;
  int                    owner_live;
  logic                  serve_any;
  logic [TILE_W-1:0]     serve_tile;
  logic [MAX_BOMBS-1:0]  serve_onehot;

  // Handshake: pN_place is a level held until pN_grant or pN_deny pulses one
  // cycle after sampling; the request is ignored during its own outcome cycle.
  always_comb begin
    req1        = p1_place && !(p1_grant || p1_deny);
    req2        = p2_place && !(p2_grant || p2_deny);
    pick_p2     = req2 && (!req1 || prio_p2);
    any_req     = req1 || req2;
    want_tile   = pick_p2 ? p2_tile : p1_tile;
    owner_live  = 0;
    tile_taken  = 1'b0;
    has_idle    = 1'b0;
    free_onehot = '0;
    for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
      if (slot_state[i] == SLOT_IDLE) begin
        has_idle       = 1'b1;
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end else begin
        if (slot_owner[i] == pick_p2) owner_live = owner_live + 1;
        if (slot_tile[i] == want_tile) tile_taken = 1'b1;
      end
    end
    accept    = any_req && !clear && has_idle && !tile_taken && (owner_live < PLAYER_LIMIT);
    reject    = any_req && !clear && !accept;
    alloc_vec = accept ? free_onehot : '0;
  end

`ifdef BOMB_CHAIN_EN
  always_comb begin
    for (int i = 0; i < MAX_BOMBS; i++) begin
      chain_hit[i] = chain_valid && (slot_tile[i] == chain_tile);
    end
  end
`else
  assign chain_hit = '0;
`endif

  for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
    bomb_slot #(
      .FUSE_TICKS (8'(FUSE_TICKS)),
      .BLAST_TICKS(8'(BLAST_TICKS))
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .tick       (tick),
      .alloc      (alloc_vec[g]),
      .alloc_tile (want_tile),
      .alloc_owner(pick_p2),
      .chain_hit  (chain_hit[g]),
      .state      (slot_state[g]),
      .tile       (slot_tile[g]),
      .owner      (slot_owner[g]),
      .fire       (fire[g])
    );
  end

  // Serve the lowest pending detonation; a new detonation sets its flag on the same edge.
  always_comb begin
    serve_any    = 1'b0;
    serve_tile   = '0;
    serve_onehot = '0;
    for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        serve_any       = 1'b1;
        serve_tile      = slot_tile[i];
        serve_onehot    = '0;
        serve_onehot[i] = 1'b1;
      end
    end
    pending_next = (pending & ~serve_onehot) | fire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p1_grant      <= 1'b0;
      p2_grant      <= 1'b0;
      p1_deny       <= 1'b0;
      p2_deny       <= 1'b0;
      prio_p2       <= 1'b0;
      pending       <= '0;
      explode_start <= 1'b0;
      explode_tile  <= '0;
    end else if (clear) begin
      p1_grant      <= 1'b0;
      p2_grant      <= 1'b0;
      p1_deny       <= 1'b0;
      p2_deny       <= 1'b0;
      pending       <= '0;
      explode_start <= 1'b0;
      explode_tile  <= '0;
    end else begin
      p1_grant      <= accept && !pick_p2;
      p2_grant      <= accept && pick_p2;
      p1_deny       <= reject && !pick_p2;
      p2_deny       <= reject && pick_p2;
      if (req1 && req2) prio_p2 <= !prio_p2;
      pending       <= pending_next;
      explode_start <= serve_any;
      explode_tile  <= serve_tile;
    end
  end

  always_comb begin
    bomb_active    = 1'b0;
    bomb_exploding = 1'b0;
    bomb_tile      = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (bomb_id == 3'(i)) begin
        bomb_active    = (slot_state[i] != SLOT_IDLE);
        bomb_exploding = (slot_state[i] == SLOT_EXPLODING);
        bomb_tile      = (slot_state[i] != SLOT_IDLE) ? slot_tile[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Randomized bench for bomb_scheduler against a slot-level behavioural model,
// with directed phases for fuse/blast timing, arbitration, denies and reset/clear.
module tb_bomb_scheduler;

  localparam int FUSE  = 180;
  localparam int BLAST = 30;
  localparam int LIMIT = 3;

  logic       clock = 1'b0;
  logic       reset, tick, clear;
  logic       p1_place, p2_place;
  logic [6:0] p1_tile, p2_tile;
  logic       p1_grant, p2_grant, p1_deny, p2_deny;
  logic [2:0] bomb_id;
  logic       bomb_active, bomb_exploding;
  logic [6:0] bomb_tile;
  logic       explode_start;
  logic [6:0] explode_tile;
`ifdef BOMB_CHAIN_EN
  logic       chain_valid;
  logic [6:0] chain_tile;
`endif

  // Model state: 0 idle, 1 armed, 2 exploding.
  int  m_state [6];
  int  m_tile  [6];
  int  m_owner [6];
  int  m_timer [6];
  bit  m_pend  [6];
  bit  m_prio;
  bit  m_g1, m_g2, m_d1, m_d2, m_es;
  int  m_et;

  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  bomb_scheduler #(.FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST), .PLAYER_LIMIT(LIMIT)) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .clear         (clear),
`ifdef BOMB_CHAIN_EN
    .chain_valid   (chain_valid),
    .chain_tile    (chain_tile),
`endif
    .p1_place      (p1_place),
    .p2_place      (p2_place),
    .p1_tile       (p1_tile),
    .p2_tile       (p2_tile),
    .p1_grant      (p1_grant),
    .p2_grant      (p2_grant),
    .p1_deny       (p1_deny),
    .p2_deny       (p2_deny),
    .bomb_id       (bomb_id),
    .bomb_active   (bomb_active),
    .bomb_exploding(bomb_exploding),
    .bomb_tile     (bomb_tile),
    .explode_start (explode_start),
    .explode_tile  (explode_tile)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_state[i] = 0; m_tile[i] = 0; m_owner[i] = 0; m_timer[i] = 0; m_pend[i] = 0;
    end
    m_prio = 0; m_g1 = 0; m_g2 = 0; m_d1 = 0; m_d2 = 0; m_es = 0; m_et = 0;
  endtask

  // Computes the model state after the coming clock edge from the present inputs.
  task automatic model_step();
    bit r1, r2, hit;
    int who, want, live, free, alloc_slot;
    if (reset) begin
      model_reset();
      return;
    end
    r1 = p1_place && !(m_g1 || m_d1);
    r2 = p2_place && !(p2_grant_model_mask());
    m_g1 = 0; m_g2 = 0; m_d1 = 0; m_d2 = 0;
    if (clear) begin
      for (int i = 0; i < 6; i++) begin m_state[i] = 0; m_timer[i] = 0; m_pend[i] = 0; end
      m_es = 0; m_et = 0;
      return;
    end
    who = -1;
    if (r1 && r2) who = m_prio ? 1 : 0;
    else if (r1)  who = 0;
    else if (r2)  who = 1;
    alloc_slot = -1;
    if (who >= 0) begin
      want = (who == 1) ? int'(p2_tile) : int'(p1_tile);
      live = 0; free = -1; hit = 0;
      for (int i = 0; i < 6; i++) begin
        if (m_state[i] != 0) begin
          if (m_owner[i] == who) live++;
          if (m_tile[i] == want) hit = 1;
        end else if (free < 0) free = i;
      end
      if (live >= LIMIT || hit || free < 0) begin
        if (who == 0) m_d1 = 1; else m_d2 = 1;
      end else begin
        if (who == 0) m_g1 = 1; else m_g2 = 1;
        alloc_slot = free;
        m_tile[free]  = want;
        m_owner[free] = who;
      end
    end
    if (r1 && r2) m_prio = !m_prio;
    m_es = 0; m_et = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_pend[i]) begin
        m_es = 1; m_et = m_tile[i]; m_pend[i] = 0;
        break;
      end
    end
    if (m_es) exp_q.push_back(7'(m_et));
    for (int i = 0; i < 6; i++) begin
      bit chained = 0;
`ifdef BOMB_CHAIN_EN
      chained = chain_valid && (m_tile[i] == int'(chain_tile));
`endif
      if (i == alloc_slot) begin
        m_state[i] = 1; m_timer[i] = FUSE;
      end else if (m_state[i] == 1) begin
        if ((tick && m_timer[i] == 1) || chained) begin
          m_state[i] = 2; m_timer[i] = BLAST; m_pend[i] = 1;
        end else if (tick) m_timer[i]--;
      end else if (m_state[i] == 2 && tick) begin
        if (m_timer[i] == 1) begin m_state[i] = 0; m_timer[i] = 0; end
        else m_timer[i]--;
      end
    end
  endtask

  function automatic bit p2_grant_model_mask();
    return m_g2 || m_d2;
  endfunction

  task automatic compare_outputs();
    int id;
    check("p1_grant", p1_grant, m_g1);
    check("p2_grant", p2_grant, m_g2);
    check("p1_deny", p1_deny, m_d1);
    check("p2_deny", p2_deny, m_d2);
    check("explode_start", explode_start, m_es);
    check("explode_tile", explode_tile, m_et);
    if (explode_start) begin
      if (exp_q.size() == 0) check("explode_unexpected", 1, 0);
      else check("explode_q_tile", explode_tile, exp_q.pop_front());
    end
    id = int'(bomb_id);
    if (id < 6) begin
      check("bomb_active", bomb_active, m_state[id] != 0);
      check("bomb_exploding", bomb_exploding, m_state[id] == 2);
      check("bomb_tile", bomb_tile, (m_state[id] != 0) ? m_tile[id] : 0);
    end else begin
      check("bomb_active_oob", bomb_active, 0);
      check("bomb_exploding_oob", bomb_exploding, 0);
      check("bomb_tile_oob", bomb_tile, 0);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    bomb_id = 3'($urandom_range(0, 7));
    #1;
    compare_outputs();
  endtask

  task automatic drop_done();
    if (p1_place && (m_g1 || m_d1)) p1_place = 0;
    if (p2_place && (m_g2 || m_d2)) p2_place = 0;
  endtask

  task automatic place(input int who, input int tile);
    bit done = 0;
    if (who == 0) begin p1_place = 1; p1_tile = 7'(tile); end
    else begin p2_place = 1; p2_tile = 7'(tile); end
    for (int k = 0; k < 8 && !done; k++) begin
      cycle();
      if (who == 0 ? (m_g1 || m_d1) : (m_g2 || m_d2)) done = 1;
    end
    check("place_outcome", done, 1);
    if (who == 0) p1_place = 0; else p2_place = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; tick = 0; clear = 0; p1_place = 0; p2_place = 0;
    p1_tile = 0; p2_tile = 0; bomb_id = 0;
`ifdef BOMB_CHAIN_EN
    chain_valid = 0; chain_tile = 0;
`endif
    model_reset();
    @(negedge clock);
    repeat (3) cycle();
    reset = 0;
    cycle();

    // Single bomb: full fuse then blast.
    place(0, 12);
    tick = 1;
    repeat (215) cycle();
    tick = 0;

    // Simultaneous requests, twice.
    for (int r = 0; r < 2; r++) begin
      p1_place = 1; p1_tile = 7'(20 + 2 * r);
      p2_place = 1; p2_tile = 7'(21 + 2 * r);
      repeat (4) begin cycle(); drop_done(); end
    end
    clear = 1; cycle(); clear = 0; cycle();

    // Fill every slot, exercise denies, then detonate all on one tick.
    place(0, 1); place(0, 2); place(0, 3); place(0, 40);
    place(1, 4); place(1, 2); place(1, 5); place(1, 6); place(1, 12);
    tick = 1;
    repeat (220) cycle();
    tick = 0;

    // Reset mid-fuse, then clear mid-fuse.
    place(0, 7);
    tick = 1; repeat (50) cycle();
    reset = 1; cycle(); reset = 0;
    repeat (200) cycle();
    tick = 0;
    place(1, 8);
    place(0, 9);
    tick = 1; repeat (50) cycle();
    clear = 1; cycle(); clear = 0;
    repeat (200) cycle();
    tick = 0;
    place(0, 10);

`ifdef BOMB_CHAIN_EN
    clear = 1; cycle(); clear = 0;
    place(0, 31); place(0, 33);
    chain_valid = 1; chain_tile = 7'd33; cycle(); chain_valid = 0;
    repeat (4) cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 699) == 0);
      clear = ($urandom_range(0, 499) == 0);
      tick  = ($urandom_range(0, 3) != 0);
      drop_done();
      if (!p1_place && $urandom_range(0, 7) == 0) begin
        p1_place = 1; p1_tile = 7'($urandom_range(0, 15));
      end
      if (!p2_place && $urandom_range(0, 7) == 0) begin
        p2_place = 1; p2_tile = 7'($urandom_range(0, 15));
      end
`ifdef BOMB_CHAIN_EN
      chain_valid = ($urandom_range(0, 15) == 0);
      chain_tile  = 7'($urandom_range(0, 15));
`endif
      cycle();
    end

    check("explode_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
